// File: rtl/perf_pkg.sv
// perf_pkg: shared state encoding and widths for the perf_counters slice
package perf_pkg;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_HALTED  = 2'd2;
    localparam int         CNT_W_DEF = 32;
    localparam int         OUT_W     = 32;
endpackage

// File: rtl/perf_counter_slice.sv
// perf_counter_slice: one event counter, wraps by default or saturates when PERF_SAT_EN is defined
module perf_counter_slice
    import perf_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             inc,
    output logic [OUT_W-1:0] q
);
    logic [CNT_W-1:0] cnt;
    logic             bump;
`ifdef PERF_SAT_EN
    assign bump = en && inc && !(&cnt);
`else
    assign bump = en && inc;
`endif
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (bump) cnt <= cnt + CNT_W'(1);
    end
    assign q = OUT_W'(cnt);
endmodule

// File: rtl/perf_counters.sv
// perf_counters: run-time pipeline statistics for the display path; PERF_SAT_EN makes counters saturate
module perf_counters
    import perf_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             halt,
    input  logic             clr,
    input  logic             br_uncond,
    input  logic             br_cond_taken,
    input  logic             bubble,
    input  logic             stall_lu,
    output logic [OUT_W-1:0] cycle_number,
    output logic [OUT_W-1:0] branch_un,
    output logic [OUT_W-1:0] branch_con,
    output logic [OUT_W-1:0] bubnum,
    output logic [OUT_W-1:0] loaduse,
    output logic             running
);
    logic [1:0]       state, state_nx;
    logic [4:0]       inc;
    logic [OUT_W-1:0] cnt [5];
    always_comb begin
        state_nx = (state == S_RUN || state == S_HALTED) ? state : S_IDLE;
        if (clr) state_nx = (state == S_RUN) ? S_RUN : S_IDLE;
        else if (state == S_IDLE && go) state_nx = S_RUN;
        else if (state == S_RUN && halt) state_nx = S_HALTED;
    end
    always_ff @(posedge clk) begin
        state <= rst ? S_IDLE : state_nx;
    end
    assign running = (state == S_RUN);
    assign inc = {stall_lu, bubble, br_cond_taken, br_uncond, 1'b1};
    for (genvar g = 0; g < 5; g++) begin : g_slice
        perf_counter_slice #(.CNT_W(CNT_W)) u_slice (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .en  (running),
            .inc (inc[g]),
            .q   (cnt[g])
        );
    end
    assign cycle_number = cnt[0];
    assign branch_un    = cnt[1];
    assign branch_con   = cnt[2];
    assign bubnum       = cnt[3];
    assign loaduse      = cnt[4];
endmodule

// File: tb/tb_perf_counters.sv
// tb_perf_counters: scoreboard bench for perf_counters at CNT_W=32 and CNT_W=4
module tb_perf_counters;
    logic clk = 1'b0;
    logic rst, go, halt, clr, bu, bc, bb, lu;
    logic [31:0] cycle_number, branch_un, branch_con, bubnum, loaduse;
    logic        running;
    logic [31:0] s_cy, s_bu, s_bc, s_bb, s_lu;
    logic        s_run;
    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] cy, bu, bc, bb, lu, c4;
        logic        run;
    } exp_t;
    exp_t sb [$];

    int          m_st = 0;
    logic [31:0] m_cy, m_bu, m_bc, m_bb, m_lu, m_c4;

    always #5 clk = ~clk;

    perf_counters dut (
        .clk(clk), .rst(rst), .go(go), .halt(halt), .clr(clr),
        .br_uncond(bu), .br_cond_taken(bc), .bubble(bb), .stall_lu(lu),
        .cycle_number(cycle_number), .branch_un(branch_un), .branch_con(branch_con),
        .bubnum(bubnum), .loaduse(loaduse), .running(running)
    );

    perf_counters #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .go(go), .halt(halt), .clr(clr),
        .br_uncond(bu), .br_cond_taken(bc), .bubble(bb), .stall_lu(lu),
        .cycle_number(s_cy), .branch_un(s_bu), .branch_con(s_bc),
        .bubnum(s_bb), .loaduse(s_lu), .running(s_run)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, g, h, c, ebu, ebc, ebb, elu);
        exp_t e;
        @(negedge clk);
        rst = r; go = g; halt = h; clr = c; bu = ebu; bc = ebc; bb = ebb; lu = elu;
        if (r) begin
            m_st = 0; m_cy = 0; m_bu = 0; m_bc = 0; m_bb = 0; m_lu = 0; m_c4 = 0;
        end else if (c) begin
            m_cy = 0; m_bu = 0; m_bc = 0; m_bb = 0; m_lu = 0; m_c4 = 0;
            if (m_st != 1) m_st = 0;
        end else if (m_st == 0) begin
            if (g) m_st = 1;
        end else if (m_st == 1) begin
            m_cy = m_cy + 1;
            m_bu = m_bu + 32'(ebu);
            m_bc = m_bc + 32'(ebc);
            m_bb = m_bb + 32'(ebb);
            m_lu = m_lu + 32'(elu);
`ifdef PERF_SAT_EN
            m_c4 = (m_c4 == 32'd15) ? 32'd15 : m_c4 + 1;
`else
            m_c4 = (m_c4 + 1) & 32'hF;
`endif
            if (h) m_st = 2;
        end
        e = '{m_cy, m_bu, m_bc, m_bb, m_lu, m_c4, m_st == 1};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("cycle_number", cycle_number, e.cy);
        chk("branch_un", branch_un, e.bu);
        chk("branch_con", branch_con, e.bc);
        chk("bubnum", bubnum, e.bb);
        chk("loaduse", loaduse, e.lu);
        chk("running", 32'(running), 32'(e.run));
        chk("cycle_number_w4", s_cy, e.c4);
    endtask

    initial begin
        logic [19:0] t_bu, t_bc, t_bb, t_lu;
        rst = 1; go = 0; halt = 0; clr = 0; bu = 0; bc = 0; bb = 0; lu = 0;
        t_bu = 20'h00224;
        t_bc = 20'h008AA;
        t_bb = 20'h09030;
        t_lu = 20'h00240;
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_cycle", cycle_number, 32'd0);
        chk("reset_running", 32'(running), 32'd0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1, i[0], 1, 0);
        chk("run10_cycle", cycle_number, 32'd10);
        cyc(1, 0, 0, 0, 1, 1, 1, 1);
        chk("midrst_cycle", cycle_number, 32'd0);
        chk("midrst_bu", branch_un, 32'd0);
        chk("midrst_running", 32'(running), 32'd0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 1, 1, 1);
        chk("idle_ignore_bu", branch_un, 32'd0);
        chk("idle_ignore_cy", cycle_number, 32'd0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        chk("go_not_counted", cycle_number, 32'd0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, t_bu[i], t_bc[i], t_bb[i], t_lu[i]);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        chk("prog_cycle", cycle_number, 32'd21);
        chk("prog_bu", branch_un, 32'd3);
        chk("prog_bc", branch_con, 32'd5);
        chk("prog_bb", bubnum, 32'd4);
        chk("prog_lu", loaduse, 32'd2);
        chk("prog_halted", 32'(running), 32'd0);
        for (int i = 0; i < 50; i++)
            cyc(0, 1'($urandom), 1'($urandom), 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        chk("frozen_cycle", cycle_number, 32'd21);
        chk("frozen_bc", branch_con, 32'd5);
        cyc(0, 0, 0, 1, 1, 0, 0, 0);
        chk("clr_halt_cycle", cycle_number, 32'd0);
        chk("clr_halt_running", 32'(running), 32'd0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("clr_halt_idle", branch_un, 32'd0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("restart_cycle", cycle_number, 32'd5);
        chk("restart_bu", branch_un, 32'd5);
        cyc(0, 0, 0, 1, 1, 1, 0, 0);
        chk("clr_run_cycle", cycle_number, 32'd0);
        chk("clr_run_bu", branch_un, 32'd0);
        chk("clr_run_running", 32'(running), 32'd1);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("after_clr_bu", branch_un, 32'd1);
        chk("after_clr_cycle", cycle_number, 32'd1);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("w32_17", cycle_number, 32'd17);
`ifdef PERF_SAT_EN
        chk("w4_sat_17", s_cy, 32'd15);
`else
        chk("w4_wrap_17", s_cy, 32'd1);
`endif
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 1, 0, 0, 0);
`ifdef PERF_SAT_EN
        chk("w4_sat_held", s_cy, 32'd15);
`else
        chk("w4_wrap_held", s_cy, 32'd2);
`endif
        chk("w32_held", cycle_number, 32'd18);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/perf_counters.md
Name: perf_counters

Overview:
- Upstream statistics stage for the 7-segment display path in the pipelined CPU.
- Counts the following run-time events from the pipeline: total cycles, unconditional jumps, taken conditional branches, inserted bubbles and load-use stalls.
- Presents each count as a registered 32-bit value to the display-select stage: cycle_number, branch_un, branch_con, bubnum, loaduse.
- Counting starts on go and freezes on halt, so the board shows final statistics after the program ends.

Parameters:
- CNT_W, 32: internal counter width, legal range 1..32. Outputs are zero-extended to 32 bits.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- go  in  1  pulse or level; starts counting from IDLE.
- halt  in  1  asserted by the pipeline when the halt/syscall-exit instruction retires.
- clr  in  1  synchronous clear of all counters (board button, already debounced).
- br_uncond  in  1  one unconditional jump retired this cycle.
- br_cond_taken  in  1  one taken conditional branch retired this cycle.
- bubble  in  1  one bubble inserted this cycle.
- stall_lu  in  1  load-use stall active this cycle.
- cycle_number  out  32  cycles counted in RUN.
- branch_un  out  32  unconditional jump count.
- branch_con  out  32  taken conditional branch count.
- bubnum  out  32  bubble count.
- loaduse  out  32  load-use stall cycle count.
- running  out  1  high while in RUN.

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, all five counters = 0, running = 0. This applies mid-run too: rst has priority over every other input.
- States:
  - IDLE: counters hold. go=1 → RUN on the next edge. The go cycle itself is not counted.
  - RUN: running=1.
    - cycle counter +1 every cycle, including the cycle halt is high.
    - Each event counter +1 in any cycle its input is high. All events are independent and may coincide.
    - halt=1 → HALTED; events present in that same cycle are still counted.
  - HALTED: counters frozen. go is ignored.
- clr behaviour:
  - In IDLE or HALTED: zero all counters and go to IDLE.
  - In RUN: zero all counters and stay in RUN. Events and the cycle tick in the clr cycle are discarded, so counters read 0 the next cycle.
- Priority: rst > clr > halt > count.
- Latency: outputs are registered. An event in cycle N is visible on the output in cycle N+1. No combinational input→output path.
- Overflow without the optional feature: each counter wraps modulo 2^CNT_W (all-ones +1 → 0). Counters wrap independently.
- Event inputs are ignored outside RUN.

Optional Feature:
- Macro PERF_SAT_EN.
- Defined: each counter saturates at 2^CNT_W−1 and holds there until clr or rst.
- Undefined: counters wrap as described under Behaviour.

Decomposition:
- Shared package perf_pkg holds:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_HALTED=2'd2;
  - CNT_W default;
  - the 32-bit output width constant.
- One sub-module, perf_counter_slice: one CNT_W counter with inc, clr, en inputs, optional saturation under PERF_SAT_EN, and zero-extended 32-bit output. It is instantiated five times.
- The FSM lives in the top level.

Test Plan:
- rst mid-RUN after 10 cycles → next cycle all outputs 0, running=0, state IDLE; event pulses ignored until go.
- go, then 20 cycles RUN with br_uncond high on 3 cycles, br_cond_taken on 5, bubble on 4, stall_lu on 2 (two events coinciding in one cycle), then halt → cycle_number=21 (including halt cycle), branch_un=3, branch_con=5, bubnum=4, loaduse=2; values stable for 50 further cycles with random events and go pulses.
- clr in RUN while br_uncond=1 → all outputs 0 the next cycle, running stays 1; following cycle with br_uncond=1 → branch_un=1.
- clr in HALTED → outputs 0, state IDLE; go restarts counting from 0.
- CNT_W=4, macro undefined: 17 RUN cycles → cycle_number=1 (wrapped).
- CNT_W=4, PERF_SAT_EN defined: 17 RUN cycles → cycle_number=15 and held.
